seg_scan_mux: RTL

//  Time-multiplexes two 7-segment patterns from the binary-to-two-digit decoder onto one shared

---
 rtl/seg_disp_pkg.sv | 35 +++
 rtl/seg_dwell_timer.sv | 33 +++
 rtl/seg_scan_mux.sv | 139 +++++++++++++
 3 files changed

// File: rtl/seg_disp_pkg.sv
// Shared constants and scan-state encoding for the 2-digit
// multiplexed 7-segment display path.
package seg_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'b0000001;
    localparam logic [1:0] AN_OFF    = 2'b11;
    localparam logic [1:0] AN_DIG0   = 2'b10;
    localparam logic [1:0] AN_DIG1   = 2'b01;

    typedef enum logic [1:0] {
        ST_GUARD1 = 2'd0,
        ST_DIG0   = 2'd1,
        ST_GUARD0 = 2'd2,
        ST_DIG1   = 2'd3
    } scan_state_e;

    function automatic scan_state_e scan_next(input scan_state_e s);
        scan_state_e n;
        n = ST_GUARD1;
        unique case (s)
            ST_GUARD1: n = ST_DIG0;
            ST_DIG0:   n = ST_GUARD0;
            ST_GUARD0: n = ST_DIG1;
            ST_DIG1:   n = ST_GUARD1;
            default:   n = ST_GUARD1;
        endcase
        return n;
    endfunction

    function automatic logic is_digit_slot(input scan_state_e s);
        return (s == ST_DIG0) || (s == ST_DIG1);
    endfunction

endpackage

// File: rtl/seg_dwell_timer.sv
// Loadable dwell counter: counts 0..dwell_i-1, flags done_o on the
// last count and clears when restart_i is asserted.
module seg_dwell_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] dwell_i,
    input  logic             restart_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign done_o = (cnt_q == (dwell_i - CNT_W'(1)));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Double-buffered 2-digit segment scanner with guard slots.
// Optional: LEADING_ZERO_BLANK_EN blanks a tens digit showing '0'.
module seg_scan_mux
    import seg_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 1000,
    parameter int GUARD_CYC   = 50,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [6:0] seg0_in,
    input  logic [6:0] seg1_in,
    output logic [6:0] seg_out,
    output logic [1:0] an,
    output logic       frame_tick,
    output logic       pending
);

    scan_state_e state_q, state_d;
    logic [6:0]  shadow0_q, shadow0_d;
    logic [6:0]  shadow1_q, shadow1_d;
    logic [6:0]  active0_q, active0_d;
    logic [6:0]  active1_q, active1_d;
    logic [6:0]  seg_q, seg_d;
    logic [1:0]  an_q, an_d;
    logic        tick_q, tick_d;
    logic        pend_q, pend_d;

    logic [CNT_W-1:0] dwell;
    logic             dwell_done;
    logic             advance;
    logic             promote;
    logic             blank1;

    assign dwell   = is_digit_slot(state_q) ? CNT_W'(REFRESH_DIV)
                                            : CNT_W'(GUARD_CYC);
    assign advance = dwell_done;

    seg_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .dwell_i   (dwell),
        .restart_i (advance),
        .done_o    (dwell_done)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign blank1 = (active1_d == SEG_ZERO);
`else
    assign blank1 = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        promote = 1'b0;
        if (advance) begin
            state_d = scan_next(state_q);
            promote = (state_q == ST_GUARD1);
        end
    end

    // Promotion happens only while both digits are dark, so a frame never tears
    always_comb begin
        shadow0_d = shadow0_q;
        shadow1_d = shadow1_q;
        active0_d = active0_q;
        active1_d = active1_q;
        pend_d    = pend_q;
        if (load) begin
            shadow0_d = seg0_in;
            shadow1_d = seg1_in;
        end
        if (promote) begin
            active0_d = load ? seg0_in : shadow0_q;
            active1_d = load ? seg1_in : shadow1_q;
            pend_d    = 1'b0;
        end else if (load) begin
            pend_d    = 1'b1;
        end
    end

    // Outputs are decoded from next state so they line up with the slot
    always_comb begin
        seg_d  = SEG_BLANK;
        an_d   = AN_OFF;
        tick_d = 1'b0;
        unique case (state_d)
            ST_DIG0: begin
                seg_d  = active0_d;
                an_d   = AN_DIG0;
                tick_d = promote;
            end
            ST_DIG1: begin
                if (!blank1) begin
                    seg_d = active1_d;
                    an_d  = AN_DIG1;
                end
            end
            default: begin
                seg_d = SEG_BLANK;
                an_d  = AN_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_GUARD1;
            shadow0_q <= SEG_BLANK;
            shadow1_q <= SEG_BLANK;
            active0_q <= SEG_BLANK;
            active1_q <= SEG_BLANK;
            seg_q     <= SEG_BLANK;
            an_q      <= AN_OFF;
            tick_q    <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow0_q <= shadow0_d;
            shadow1_q <= shadow1_d;
            active0_q <= active0_d;
            active1_q <= active1_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            tick_q    <= tick_d;
            pend_q    <= pend_d;
        end
    end

    assign seg_out    = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;
    assign pending    = pend_q;

endmodule
